// File: rtl/debounce_counter_n.sv
// debounce_counter_n: CH independent debounced button channels, each with a
// lockout FSM, a wrapping event counter and a sticky overflow flag.
// Optional feature: define DEBOUNCE_AUTOREPEAT_EN to make a button held in
// WAIT_REL re-fire every RPT cycles. Default build has no repeat logic.

module debounce_lane #(
  parameter int CNT_W = 8,
  parameter int DLY   = 2**20,
  parameter int RPT   = 2**22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             clr,
  output logic             evt,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  // One counter serves every timed state, so size it for the longer period.
  localparam int LMAX = (DLY > RPT) ? DLY : RPT;
  localparam int LW   = $clog2(LMAX + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PULSE    = 3'd1;
  localparam logic [2:0] LOCK_P   = 3'd2;
  localparam logic [2:0] WAIT_REL = 3'd3;
  localparam logic [2:0] LOCK_R   = 3'd4;

  localparam logic [LW-1:0] DLY_LAST = LW'(DLY - 1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [LW-1:0] RPT_LAST = LW'(RPT - 1);
`endif

  logic [1:0]    sync_pipe;
  logic          s_btn;
  logic [2:0]    state, state_nx;
  logic [LW-1:0] lk, lk_nx;

  // Two-flop synchronizer on the raw, asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], btn};
  end

  assign s_btn = sync_pipe[1];

  // Next-state logic; lk is zeroed on every entry into a timed state.
  always_comb begin
    state_nx = state;
    lk_nx    = lk;
    case (state)
      IDLE: begin
        if (s_btn) state_nx = PULSE;
      end
      PULSE: begin
        state_nx = LOCK_P;
        lk_nx    = '0;
      end
      LOCK_P: begin
        if (lk == DLY_LAST) begin
          state_nx = WAIT_REL;
          lk_nx    = '0;
        end else begin
          lk_nx = lk + LW'(1);
        end
      end
      WAIT_REL: begin
        if (!s_btn) begin
          state_nx = LOCK_R;
          lk_nx    = '0;
        end
`ifdef DEBOUNCE_AUTOREPEAT_EN
        else if (lk == RPT_LAST) begin
          state_nx = PULSE;
        end else begin
          lk_nx = lk + LW'(1);
        end
`endif
      end
      LOCK_R: begin
        if (lk == DLY_LAST) state_nx = IDLE;
        else                lk_nx    = lk + LW'(1);
      end
      default: begin
        state_nx = IDLE;
        lk_nx    = '0;
      end
    endcase
  end

  // FSM and lockout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lk    <= '0;
    end else begin
      state <= state_nx;
      lk    <= lk_nx;
    end
  end

  assign evt = (state == PULSE);

  // Event counter: the count lands on the edge that ends PULSE; a clear in
  // that same cycle keeps the press, so the result is 1 rather than 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= evt ? CNT_W'(1) : '0;
      ovf <= 1'b0;
    end else if (evt) begin
      cnt <= cnt + CNT_W'(1);
      if (&cnt) ovf <= 1'b1;
    end
  end

endmodule

module debounce_counter_n #(
  parameter int CH    = 4,
  parameter int CNT_W = 8,
  parameter int DLY   = 2**20,
  parameter int RPT   = 2**22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       btn,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       evt,
  output logic [CH*CNT_W-1:0] cnt_out,
  output logic [CH-1:0]       ovf
);
  logic [CH-1:0][CNT_W-1:0] cnt_arr;

  // Fully independent lanes; nothing is shared between channels.
  for (genvar i = 0; i < CH; i++) begin : g_lane
    debounce_lane #(
      .CNT_W(CNT_W),
      .DLY  (DLY),
      .RPT  (RPT)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .btn(btn[i]),
      .clr(clr[i]),
      .evt(evt[i]),
      .cnt(cnt_arr[i]),
      .ovf(ovf[i])
    );
  end

  assign cnt_out = cnt_arr;

endmodule

// File: tb/tb_debounce_counter_n.sv
// Self-checking bench for debounce_counter_n: directed scenarios followed by
// randomized button/clear/reset traffic, all compared every cycle against a
// timestamp-based reference model.

module tb_debounce_counter_n;
  localparam int CH    = 4;
  localparam int CNT_W = 4;
  localparam int DLY   = 8;
  localparam int RPT   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH-1:0]       btn;
  logic [CH-1:0]       clr;
  logic [CH-1:0]       evt;
  logic [CH*CNT_W-1:0] cnt_out;
  logic [CH-1:0]       ovf;

  debounce_counter_n #(.CH(CH), .CNT_W(CNT_W), .DLY(DLY), .RPT(RPT)) dut (
    .clk(clk), .rst(rst), .btn(btn), .clr(clr),
    .evt(evt), .cnt_out(cnt_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int obs_evt [CH];

  // Reference model: btn history two samples deep, plus per channel the
  // earliest edge a new press may be accepted, and while the button is still
  // held, the first edge at which a release (or repeat) is evaluated.
  logic [CH-1:0] b1, b2;
  logic [CH-1:0] m_evt, m_ovf, m_hold;
  int            m_cnt   [CH];
  int            ok_at   [CH];
  int            rel_from[CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [CH*CNT_W-1:0] m_cnt_vec();
    logic [CH*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    return v;
  endfunction

  task automatic model_step(input logic r, input logic [CH-1:0] b, input logic [CH-1:0] c);
    logic [CH-1:0] e;
    logic          s;
    if (r) begin
      b1 = '0; b2 = '0; m_evt = '0; m_ovf = '0; m_hold = '0;
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; ok_at[i] = 0; rel_from[i] = 0;
      end
    end else begin
      e = '0;
      for (int i = 0; i < CH; i++) begin
        s = b2[i];
        if (m_hold[i]) begin
          if (cyc >= rel_from[i]) begin
            if (!s) begin
              m_hold[i] = 1'b0;
              ok_at[i]  = cyc + DLY + 1;
            end
`ifdef DEBOUNCE_AUTOREPEAT_EN
            else if (cyc == rel_from[i] + RPT - 1) begin
              e[i]        = 1'b1;
              rel_from[i] = cyc + DLY + 2;
            end
`endif
          end
        end else if (cyc >= ok_at[i] && s) begin
          e[i]        = 1'b1;
          m_hold[i]   = 1'b1;
          rel_from[i] = cyc + DLY + 2;
        end
        // counter sees the pulse issued on the previous edge
        if (c[i]) begin
          m_cnt[i] = m_evt[i] ? 1 : 0;
          m_ovf[i] = 1'b0;
        end else if (m_evt[i]) begin
          if (m_cnt[i] == 2**CNT_W - 1) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      m_evt = e;
      b2 = b1;
      b1 = b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(rst, btn, clr);
    #1;
    for (int i = 0; i < CH; i++) if (evt[i] === 1'b1) obs_evt[i]++;
    chk("evt_model", 32'(evt), 32'(m_evt));
    chk("cnt_model", 32'(cnt_out), 32'(m_cnt_vec()));
    chk("ovf_model", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic press(input int ch, input int hi, input int lo);
    btn[ch] = 1'b1;
    ticks(hi);
    btn[ch] = 1'b0;
    ticks(lo);
  endtask

  initial begin
    int pos[$];
    for (int i = 0; i < CH; i++) obs_evt[i] = 0;
    rst = 1'b1; btn = '0; clr = '0;
    ticks(3);
    chk("reset_evt", 32'(evt), 32'd0);
    chk("reset_cnt", 32'(cnt_out), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    ticks(5);

    // clean press on ch0
    btn[0] = 1'b1;
    tick(); tick();
    chk("clean_early", 32'(evt[0]), 32'd0);
    tick();
    chk("clean_lat", 32'(evt[0]), 32'd1);
    ticks(37);
    btn[0] = 1'b0;
    ticks(30);
    chk("clean_cnt0", 32'(cnt_out[0 +: CNT_W]), 32'd1);
    chk("clean_others", 32'(cnt_out[CH*CNT_W-1:CNT_W]), 32'd0);
    chk("clean_nevt", 32'(obs_evt[0]), 32'd1);

    // bouncing press on ch1
    btn[1] = 1'b1; ticks(2);
    btn[1] = 1'b0; ticks(2);
    btn[1] = 1'b1; ticks(32);
    btn[1] = 1'b0; ticks(30);
    chk("bounce_nevt", 32'(obs_evt[1]), 32'd1);
    chk("bounce_cnt1", 32'(cnt_out[CNT_W +: CNT_W]), 32'd1);

    // wrap on ch2, clear, then clear coincident with the count edge
    for (int p = 0; p < 16; p++) press(2, 14, 14);
    chk("wrap_cnt2", 32'(cnt_out[2*CNT_W +: CNT_W]), 32'd0);
    chk("wrap_ovf2", 32'(ovf[2]), 32'd1);
    clr[2] = 1'b1; tick(); clr[2] = 1'b0; tick();
    chk("clr_ovf2", 32'(ovf[2]), 32'd0);
    btn[2] = 1'b1;
    ticks(3);
    chk("clr_pulse_evt", 32'(evt[2]), 32'd1);
    clr[2] = 1'b1; tick(); clr[2] = 1'b0;
    chk("clr_pulse_cnt", 32'(cnt_out[2*CNT_W +: CNT_W]), 32'd1);
    chk("clr_pulse_ovf", 32'(ovf[2]), 32'd0);
    ticks(14);
    btn[2] = 1'b0;
    ticks(30);

    // reset during LOCK_P with ch3 held
    btn[3] = 1'b1;
    ticks(8);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_evt", 32'(evt), 32'd0);
    chk("rst_mid_cnt", 32'(cnt_out), 32'd0);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);
    tick(); tick();
    chk("rst_rel_early", 32'(evt[3]), 32'd0);
    tick();
    chk("rst_rel_evt", 32'(evt[3]), 32'd1);
    ticks(14);
    btn[3] = 1'b0;
    ticks(30);

    // long hold on ch0: auto-repeat when enabled, single press otherwise
    btn[0] = 1'b1;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (evt[0] === 1'b1) pos.push_back(t);
    end
    btn[0] = 1'b0;
    ticks(30);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    chk("rpt_n", 32'(pos.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("rpt_at", (k < pos.size()) ? 32'(pos[k]) : 32'hffff_ffff, 32'(3 + 25*k));
    chk("rpt_cnt0", 32'(cnt_out[0 +: CNT_W]), 32'd4);
`else
    chk("rpt_n", 32'(pos.size()), 32'd1);
    chk("rpt_at", (pos.size() > 0) ? 32'(pos[0]) : 32'hffff_ffff, 32'd3);
    chk("rpt_cnt0", 32'(cnt_out[0 +: CNT_W]), 32'd1);
`endif

    // randomized traffic: slow toggles make both presses and bounces
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      clr = ($urandom_range(0, 29) == 0) ? CH'($urandom) : '0;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; btn = '0; clr = '0;
    ticks(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_counter_n.md
DEBOUNCE_COUNTER_N -- requirements
Module: debounce_counter_n

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent channels, 1..16.
REQ-002 SHALL have parameter CNT_W, default 8: per-channel event counter width, 2..16.
REQ-003 SHALL have parameter DLY, default 2**20: lockout length in clk cycles, >=1.
REQ-004 SHALL have parameter RPT, default 2**22: auto-repeat period in clk cycles, >=1; used only under REQ-027.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port btn  input  CH  raw asynchronous, bouncing button inputs, active-high.
REQ-008 SHALL have port clr  input  CH  synchronous per-channel counter clear, active-high.
REQ-009 SHALL have port evt  output  CH  one-cycle pulse per accepted press.
REQ-010 SHALL have port cnt_out  output  CH*CNT_W  channel i's counter at bits [i*CNT_W +: CNT_W].
REQ-011 SHALL have port ovf  output  CH  sticky wrap flag per channel.

Function
REQ-012 SHALL pass each btn bit through a 2-flop synchronizer; the FSM sees only the synchronized value s_btn.
REQ-013 SHALL run one independent FSM per channel with states IDLE, PULSE, LOCK_P, WAIT_REL, LOCK_R.
REQ-014 Transitions SHALL be:
- IDLE: s_btn=1 -> PULSE.
- PULSE: unconditionally -> LOCK_P; lasts exactly 1 cycle.
- LOCK_P: ignores s_btn for exactly DLY cycles -> WAIT_REL.
- WAIT_REL: s_btn=0 -> LOCK_R.
- LOCK_R: ignores s_btn for exactly DLY cycles -> IDLE.
REQ-015 evt[i] SHALL be high exactly during PULSE; first-sampled btn high yields evt 3 cycles later (2 sync + 1 FSM).
REQ-016 The counter SHALL increment by 1 at the clock edge ending PULSE; cnt_out is registered and updates the cycle after evt.
REQ-017 The counter SHALL wrap from 2**CNT_W-1 to 0 and set ovf[i]; ovf stays set until clr[i] or rst.
REQ-018 clr[i] SHALL set counter i to 0 and clear ovf[i] at the next edge without affecting FSM state.
REQ-019 clr[i] and the increment in the same cycle SHALL give counter=1 and ovf[i]=0; the press is not lost.
REQ-020 Each channel SHALL own its lockout counter, width $clog2(max(DLY,RPT)+1), zeroed on each lock-state entry; channels never share or stall one another.
REQ-021 Bounces on s_btn during LOCK_P or LOCK_R SHALL produce no evt and no count.
REQ-022 Simultaneous presses on several channels SHALL each produce their own evt in the same cycle.

Reset
REQ-023 On rst=1 at a clock edge, every FSM SHALL go to IDLE and synchronizers, lockout counters, counters, evt and ovf SHALL go to 0.
REQ-024 rst SHALL take priority over clr and over any in-progress PULSE or lock state.
REQ-025 A button held through reset release SHALL count as a new press: evt 3 cycles after the first edge with rst=0.

Configuration
REQ-026 Macro DEBOUNCE_AUTOREPEAT_EN SHALL select the auto-repeat feature.
REQ-027 With the macro defined: in WAIT_REL, if s_btn stays 1 for RPT consecutive cycles, the FSM SHALL go -> PULSE (new evt and count); the RPT count restarts on each WAIT_REL entry.
REQ-028 Without the macro: WAIT_REL SHALL leave only on s_btn=0, RPT SHALL be ignored, and no repeat logic is synthesized.

Verification (CH=4, CNT_W=4, DLY=8, RPT=16)
REQ-029 SHALL cover clean press: btn[0] high 40 cycles, then low -> exactly one evt[0] 3 cycles after rise, cnt_out[3:0]=1, other channels 0.
REQ-030 SHALL cover bounce rejection: btn[1] toggling every 2 cycles for 6 cycles after rise, then steady high -> one evt[1], count 1.
REQ-031 SHALL cover wrap: 16 clean presses on ch2 -> counter 0, ovf[2]=1; then clr[2] pulse -> ovf[2]=0; clr coincident with PULSE -> counter 1.
REQ-032 SHALL cover reset mid-lock: rst at cycle 5 of LOCK_P with btn[3] held -> all outputs 0, then new evt[3] 3 cycles after rst falls.
REQ-033 SHALL cover auto-repeat (macro defined): btn[0] held 100 cycles -> evt at 3, then every 1+8+16=25 cycles (28, 53, 78), count 4; macro undefined -> count 1.
